// File: rtl/stdp_pkg.sv
// Shared default widths and saturating arithmetic helpers for the STDP layer.
package stdp_pkg;

  localparam int ST_W_DEF = 8;
  localparam int WT_W_DEF = 8;
  localparam int WIN_DEF  = 7;
  localparam int TMR_W    = $clog2(WIN_DEF + 1);

  function automatic int unsigned sat_add(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned lim);
    int unsigned s;
    s = a + b;
    return (s > lim) ? lim : s;
  endfunction

  function automatic int unsigned sat_sub(input int unsigned a,
                                          input int unsigned b);
    return (a > b) ? (a - b) : 32'd0;
  endfunction

endpackage

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: state halves each step and integrates the
// input current with saturation; fires and clears once state reaches threshold.
module lif_neuron
  import stdp_pkg::*;
#(
  parameter int ST_W = ST_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  input  logic [ST_W-1:0] current,
  input  logic [ST_W-1:0] threshold,
  output logic [ST_W-1:0] state,
  output logic            spike
);

  logic [ST_W-1:0] state_q, state_d;
  logic            spike_q, spike_d;
  logic [ST_W:0]   sum;

  always_comb begin
    sum     = {1'b0, state_q >> 1} + {1'b0, current};
    state_d = state_q;
    spike_d = 1'b0;
    if (state_q >= threshold) begin
      state_d = '0;
      spike_d = 1'b1;
    end else begin
      state_d = sum[ST_W] ? '1 : sum[ST_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
      spike_q <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      spike_q <= spike_d;
    end
  end

  assign state = state_q;
  assign spike = spike_q;

endmodule

// File: rtl/stdp_layer.sv
// N_PRE presynaptic LIF neurons feeding one postsynaptic LIF neuron through
// pair-based STDP synapses. Define STDP_EXP_EN for timing-scaled (shifted) steps.
module stdp_layer
  import stdp_pkg::*;
#(
  parameter int N_PRE   = 5,
  parameter int ST_W    = ST_W_DEF,
  parameter int WT_W    = WT_W_DEF,
  parameter int WIN     = WIN_DEF,
  parameter int A_PLUS  = 8,
  parameter int A_MINUS = 4,
  parameter int W_INIT  = 32,
  parameter int W_MAX   = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  learn_en,
  input  logic [N_PRE*ST_W-1:0] pre_current,
  input  logic [ST_W-1:0]       post_current,
  input  logic [N_PRE*ST_W-1:0] pre_thresh,
  input  logic [ST_W-1:0]       post_thresh,
  output logic [N_PRE-1:0]      pre_spike,
  output logic                  post_spike,
  output logic [ST_W-1:0]       post_state,
  output logic [N_PRE*WT_W-1:0] weights,
  output logic                  w_update
);

  localparam int TW    = $clog2(WIN + 1);
  localparam int SUM_W = ((ST_W > WT_W) ? ST_W : WT_W) + $clog2(N_PRE) + 1;

  logic [N_PRE-1:0][WT_W-1:0] w_q, w_d;
  logic [N_PRE-1:0][TW-1:0]   pre_tmr_q, pre_tmr_d;
  logic [TW-1:0]              post_tmr_q, post_tmr_d;
  logic                       w_update_q, w_update_d;
  logic [N_PRE-1:0][ST_W-1:0] pre_state_unused;
  logic [SUM_W-1:0]           acc;
  logic [ST_W-1:0]            post_cur;
  int unsigned                ltp_step, ltd_step;

  for (genvar i = 0; i < N_PRE; i++) begin : g_pre
    lif_neuron #(.ST_W(ST_W)) u_pre (
      .clk       (clk),
      .rst       (rst),
      .ena       (ena),
      .current   (pre_current[i*ST_W +: ST_W]),
      .threshold (pre_thresh[i*ST_W +: ST_W]),
      .state     (pre_state_unused[i]),
      .spike     (pre_spike[i])
    );
  end

  // Registered pre spikes gate the weights, giving one cycle of pre->post latency.
  always_comb begin
    acc = SUM_W'(post_current);
    for (int i = 0; i < N_PRE; i++) begin
      if (pre_spike[i]) acc = acc + SUM_W'(w_q[i]);
    end
    post_cur = (|acc[SUM_W-1:ST_W]) ? '1 : acc[ST_W-1:0];
  end

  lif_neuron #(.ST_W(ST_W)) u_post (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .current   (post_cur),
    .threshold (post_thresh),
    .state     (post_state),
    .spike     (post_spike)
  );

  always_comb begin
    for (int i = 0; i < N_PRE; i++) begin
      pre_tmr_d[i] = pre_spike[i] ? '0 :
                     (pre_tmr_q[i] == TW'(WIN)) ? pre_tmr_q[i] : pre_tmr_q[i] + TW'(1);
    end
    post_tmr_d = post_spike ? '0 :
                 (post_tmr_q == TW'(WIN)) ? post_tmr_q : post_tmr_q + TW'(1);
  end

  // LTP takes priority, so a same-cycle pre+post pair only potentiates.
  always_comb begin
    w_d        = w_q;
    w_update_d = 1'b0;
    ltp_step   = 32'd0;
    ltd_step   = 32'd0;
    for (int i = 0; i < N_PRE; i++) begin
`ifdef STDP_EXP_EN
      ltp_step = pre_spike[i] ? A_PLUS : (A_PLUS >> pre_tmr_q[i]);
      ltd_step = A_MINUS >> post_tmr_q;
`else
      ltp_step = A_PLUS;
      ltd_step = A_MINUS;
`endif
      if (learn_en) begin
        if (post_spike && (pre_spike[i] || (pre_tmr_q[i] < TW'(WIN))))
          w_d[i] = WT_W'(sat_add(32'(w_q[i]), ltp_step, W_MAX));
        else if (pre_spike[i] && !post_spike && (post_tmr_q < TW'(WIN)))
          w_d[i] = WT_W'(sat_sub(32'(w_q[i]), ltd_step));
      end
      if (w_d[i] != w_q[i]) w_update_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_PRE; i++) begin
        w_q[i]       <= WT_W'(W_INIT);
        pre_tmr_q[i] <= TW'(WIN);
      end
      post_tmr_q <= TW'(WIN);
      w_update_q <= 1'b0;
    end else if (ena) begin
      w_q        <= w_d;
      pre_tmr_q  <= pre_tmr_d;
      post_tmr_q <= post_tmr_d;
      w_update_q <= w_update_d;
    end
  end

  assign weights  = w_q;
  assign w_update = w_update_q;

endmodule

// File: tb/tb_stdp_layer.sv
// Self-checking bench for stdp_layer: directed vector table, hand-written STDP
// sequences and randomized traffic, all compared against an integer reference model.
module tb_stdp_layer;

  localparam int N   = 5;
  localparam int SW  = 8;
  localparam int WW  = 8;
  localparam int WIN = 7;
  localparam int AP  = 8;
  localparam int AM  = 4;
  localparam int WI  = 32;
  localparam int WM  = 255;

  logic            clk = 1'b0;
  logic            rst, ena, learn_en;
  logic [N*SW-1:0] pre_current, pre_thresh;
  logic [SW-1:0]   post_current, post_thresh;
  logic [N-1:0]    pre_spike;
  logic            post_spike;
  logic [SW-1:0]   post_state;
  logic [N*WW-1:0] weights;
  logic            w_update;

  int compared   = 0;
  int mismatched = 0;

  int mPreS[N], mPreSp[N], mW[N], mPt[N];
  int mPostS, mPostSp, mQt, mWu;

  typedef struct {
    logic          r;
    logic [SW-1:0] cur;
    logic [SW-1:0] th;
    logic [SW-1:0] expState;
    logic          expSpike;
  } vec_t;
  vec_t lifTab[$];

  logic [N*WW-1:0] allInit;

  stdp_layer #(
    .N_PRE(N), .ST_W(SW), .WT_W(WW), .WIN(WIN), .A_PLUS(AP),
    .A_MINUS(AM), .W_INIT(WI), .W_MAX(WM)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .learn_en     (learn_en),
    .pre_current  (pre_current),
    .post_current (post_current),
    .pre_thresh   (pre_thresh),
    .post_thresh  (post_thresh),
    .pre_spike    (pre_spike),
    .post_spike   (post_spike),
    .post_state   (post_state),
    .weights      (weights),
    .w_update     (w_update)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Leaky integrate-and-fire rule in plain integer arithmetic.
  task automatic lifStep(inout int s, inout int sp, input int cur, input int th);
    if (s >= th) begin
      s  = 0;
      sp = 1;
    end else begin
      s  = s / 2 + cur;
      if (s > 255) s = 255;
      sp = 0;
    end
  endtask

  task automatic modelStep();
    int acc, nw, s, sp;
    bit changed;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        mPreS[i] = 0; mPreSp[i] = 0; mW[i] = WI; mPt[i] = WIN;
      end
      mPostS = 0; mPostSp = 0; mQt = WIN; mWu = 0;
    end else if (ena) begin
      acc = int'(post_current);
      for (int i = 0; i < N; i++) if (mPreSp[i] != 0) acc += mW[i];
      if (acc > 255) acc = 255;
      changed = 0;
      for (int i = 0; i < N; i++) begin
        nw = mW[i];
        if (learn_en) begin
          if (mPostSp != 0 && (mPreSp[i] != 0 || mPt[i] < WIN))
            nw = (nw + AP > WM) ? WM : nw + AP;
          else if (mPreSp[i] != 0 && mPostSp == 0 && mQt < WIN)
            nw = (nw < AM) ? 0 : nw - AM;
        end
        if (nw != mW[i]) changed = 1;
        mW[i] = nw;
      end
      for (int i = 0; i < N; i++) mPt[i] = (mPreSp[i] != 0) ? 0 : ((mPt[i] < WIN) ? mPt[i] + 1 : WIN);
      mQt = (mPostSp != 0) ? 0 : ((mQt < WIN) ? mQt + 1 : WIN);
      for (int i = 0; i < N; i++) begin
        s = mPreS[i]; sp = mPreSp[i];
        lifStep(s, sp, int'(pre_current[i*SW +: SW]), int'(pre_thresh[i*SW +: SW]));
        mPreS[i] = s; mPreSp[i] = sp;
      end
      s = mPostS; sp = mPostSp;
      lifStep(s, sp, acc, int'(post_thresh));
      mPostS = s; mPostSp = sp;
      mWu = changed ? 1 : 0;
    end
  endtask

  task automatic checkOutput();
    logic [N-1:0]    eSp;
    logic [N*WW-1:0] eW;
    for (int i = 0; i < N; i++) begin
      eSp[i]          = (mPreSp[i] != 0);
      eW[i*WW +: WW]  = WW'(mW[i]);
    end
    checkVal("model_pre_spike", 64'(pre_spike), 64'(eSp));
    checkVal("model_post_spike", 64'(post_spike), 64'(mPostSp != 0));
    checkVal("model_post_state", 64'(post_state), 64'(mPostS));
    checkVal("model_weights", 64'(weights), 64'(eW));
    checkVal("model_w_update", 64'(w_update), 64'(mWu != 0));
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic quiet();
    pre_current  = '0;
    pre_thresh   = '1;
    post_current = '0;
    post_thresh  = 8'd255;
  endtask

  task automatic setPreTh(input int i, input int v);
    pre_thresh[i*SW +: SW] = SW'(v);
  endtask

  task automatic resetDut();
    rst = 1'b1; ena = 1'b1; learn_en = 1'b0;
    quiet();
    applyStimulus();
    rst = 1'b0;
  endtask

  task automatic addVec(input logic r, input int cur, input int th, input int st, input logic sp);
    vec_t v;
    v.r = r; v.cur = SW'(cur); v.th = SW'(th); v.expState = SW'(st); v.expSpike = sp;
    lifTab.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    allInit = {N{8'(WI)}};
    rst = 1'b1; ena = 1'b0; learn_en = 1'b0;
    quiet();
    applyStimulus();
    applyStimulus();
    checkVal("reset_post_state", 64'(post_state), 64'd0);
    checkVal("reset_pre_spike", 64'(pre_spike), 64'd0);
    checkVal("reset_post_spike", 64'(post_spike), 64'd0);
    checkVal("reset_weights", 64'(weights), 64'(allInit));
    checkVal("reset_w_update", 64'(w_update), 64'd0);
    rst = 1'b0; ena = 1'b1;

    // Post neuron LIF behaviour: period-3 firing, convergence, saturation.
    addVec(1, 0, 255, 0, 0);
    addVec(0, 50, 60, 50, 0); addVec(0, 50, 60, 75, 0); addVec(0, 50, 60, 0, 1);
    addVec(0, 50, 60, 50, 0); addVec(0, 50, 60, 75, 0); addVec(0, 50, 60, 0, 1);
    addVec(1, 50, 200, 0, 0);
    addVec(0, 50, 200, 50, 0); addVec(0, 50, 200, 75, 0); addVec(0, 50, 200, 87, 0);
    addVec(0, 50, 200, 93, 0); addVec(0, 50, 200, 96, 0); addVec(0, 50, 200, 98, 0);
    addVec(0, 50, 200, 99, 0); addVec(0, 50, 200, 99, 0);
    addVec(1, 255, 255, 0, 0);
    addVec(0, 255, 255, 255, 0); addVec(0, 255, 255, 0, 1);
    addVec(0, 255, 255, 255, 0); addVec(0, 255, 255, 0, 1);
    for (int k = 0; k < lifTab.size(); k++) begin
      rst = lifTab[k].r; post_current = lifTab[k].cur; post_thresh = lifTab[k].th;
      applyStimulus();
      checkVal("tab_post_state", 64'(post_state), 64'(lifTab[k].expState));
      checkVal("tab_post_spike", 64'(post_spike), 64'(lifTab[k].expSpike));
    end
    rst = 1'b0;

    // Weighted sum clamps without wrapping; learning off keeps weights frozen.
    resetDut();
    for (int i = 0; i < N; i++) setPreTh(i, 0);
    post_current = 8'd200;
    applyStimulus();
    checkVal("sum_first_state", 64'(post_state), 64'd200);
    checkVal("sum_all_pre", 64'(pre_spike), 64'h1f);
    applyStimulus();
    checkVal("sum_clamp", 64'(post_state), 64'd255);
    applyStimulus();
    checkVal("sum_post_fire", 64'(post_spike), 64'd1);
    applyStimulus();
    checkVal("learn_off_weights", 64'(weights), 64'(allInit));
    checkVal("learn_off_w_update", 64'(w_update), 64'd0);

    // LTP: pre0 spike, post spike three cycles later, then freeze with ena low.
    resetDut();
    learn_en = 1'b1;
    setPreTh(0, 0);
    applyStimulus();
    checkVal("ltp_pre0_spike", 64'(pre_spike), 64'd1);
    setPreTh(0, 255);
    applyStimulus();
    applyStimulus();
    post_thresh = 8'd0;
    applyStimulus();
    checkVal("ltp_post_spike", 64'(post_spike), 64'd1);
    post_thresh = 8'd255;
    applyStimulus();
    checkVal("ltp_w0", 64'(weights[7:0]), 64'd40);
    checkVal("ltp_w1_untouched", 64'(weights[15:8]), 64'd32);
    checkVal("ltp_w_update", 64'(w_update), 64'd1);
    ena = 1'b0; post_thresh = 8'd0; setPreTh(0, 0); post_current = 8'd99;
    repeat (3) applyStimulus();
    checkVal("ena_hold_w_update", 64'(w_update), 64'd1);
    checkVal("ena_hold_w0", 64'(weights[7:0]), 64'd40);
    checkVal("ena_hold_post_spike", 64'(post_spike), 64'd0);
    checkVal("ena_hold_pre_spike", 64'(pre_spike), 64'd0);
    ena = 1'b1; quiet();
    applyStimulus();
    checkVal("ltp_pulse_once", 64'(w_update), 64'd0);

    // LTD: post spike, then pre1 spike two cycles later.
    resetDut();
    learn_en = 1'b1;
    post_thresh = 8'd0; applyStimulus(); post_thresh = 8'd255;
    applyStimulus();
    setPreTh(1, 0); applyStimulus(); setPreTh(1, 255);
    applyStimulus();
    checkVal("ltd_w1", 64'(weights[15:8]), 64'd28);
    checkVal("ltd_w_update", 64'(w_update), 64'd1);

    // Pre spike arriving after the post timer has saturated: no depression.
    resetDut();
    learn_en = 1'b1;
    post_thresh = 8'd0; applyStimulus(); post_thresh = 8'd255;
    repeat (WIN) applyStimulus();
    setPreTh(1, 0); applyStimulus(); setPreTh(1, 255);
    applyStimulus();
    checkVal("window_w1", 64'(weights[15:8]), 64'd32);
    checkVal("window_w_update", 64'(w_update), 64'd0);

    // Repeated depression clamps at zero; an unchanged clamp gives no pulse.
    resetDut();
    learn_en = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      post_thresh = 8'd0; applyStimulus(); post_thresh = 8'd255;
      applyStimulus();
      setPreTh(1, 0); applyStimulus(); setPreTh(1, 255);
      applyStimulus();
      checkVal("ltd_clamp_w1", 64'(weights[15:8]), 64'((32 - 4 * n < 0) ? 0 : 32 - 4 * n));
      checkVal("ltd_clamp_w_update", 64'(w_update), 64'(n <= 8));
      repeat (WIN + 1) applyStimulus();
    end

    // Rst mid-run with ena low still restores everything.
    pre_current[7:0] = 8'd50; setPreTh(0, 60); post_current = 8'd30;
    repeat (4) applyStimulus();
    rst = 1'b1; ena = 1'b0;
    applyStimulus();
    checkVal("midrst_weights", 64'(weights), 64'(allInit));
    checkVal("midrst_pre_spike", 64'(pre_spike), 64'd0);
    checkVal("midrst_post_spike", 64'(post_spike), 64'd0);
    checkVal("midrst_post_state", 64'(post_state), 64'd0);
    checkVal("midrst_w_update", 64'(w_update), 64'd0);
    rst = 1'b0; ena = 1'b1;

    // Same-cycle pre and post spikes potentiate only.
    resetDut();
    learn_en = 1'b1;
    setPreTh(2, 0); post_thresh = 8'd0;
    applyStimulus();
    checkVal("same_pre_spike", 64'(pre_spike), 64'h4);
    checkVal("same_post_spike", 64'(post_spike), 64'd1);
    quiet();
    applyStimulus();
    checkVal("same_w2", 64'(weights[23:16]), 64'd40);

    // Continuous coincident spiking drives w0 up to the upper clamp.
    resetDut();
    learn_en = 1'b1;
    setPreTh(0, 0); post_thresh = 8'd0;
    repeat (30) applyStimulus();
    checkVal("ltp_clamp_w0", 64'(weights[7:0]), 64'd255);
    checkVal("ltp_clamp_w_update", 64'(w_update), 64'd0);
    checkVal("ltp_clamp_w1", 64'(weights[15:8]), 64'd32);

    // Randomized traffic against the reference model.
    resetDut();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        pre_current[i*SW +: SW] = SW'($urandom_range(0, 80));
        pre_thresh[i*SW +: SW]  = SW'($urandom_range(0, 150));
      end
      post_current = SW'($urandom_range(0, 60));
      post_thresh  = SW'($urandom_range(20, 255));
      rst      = ($urandom_range(0, 299) == 0);
      ena      = ($urandom_range(0, 9) != 0);
      learn_en = ($urandom_range(0, 3) != 0);
      applyStimulus();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
